// File: rtl/not_gate_monitor_if.sv
// not_gate_monitor_if: stimulus/response and result signals of the inverter monitor.
interface not_gate_monitor_if #(parameter int CNT_W = 8);
   logic             enable;
   logic             mon_in_not;
   logic             mon_out_not;
   logic             check_valid;
   logic             mismatch;
   logic [CNT_W-1:0] check_count;
   logic [CNT_W-1:0] err_count;
   logic             last_bad_in;
   logic             pass;
   modport master (
      output enable, mon_in_not, mon_out_not,
      input  check_valid, mismatch, check_count, err_count, last_bad_in, pass
   );
   modport slave (
      input  enable, mon_in_not, mon_out_not,
      output check_valid, mismatch, check_count, err_count, last_bad_in, pass
   );
endinterface

// File: rtl/not_gate_monitor.sv
// not_gate_monitor: waits for a stable inverter input, then checks the output is its complement.
module not_gate_monitor #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input logic               clk,
   input logic               reset,
   not_gate_monitor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, HOLD} state_t;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   state_t           state_q;
   logic [3:0]       settle_q;
   logic             prev_q;
   logic             cv_q;
   logic             mm_q;
   logic             lbi_q;
   logic             pass_q;
   logic [CNT_W-1:0] chk_q;
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] chk_d;
   logic [CNT_W-1:0] err_d;
   logic             bad;
   // X/Z on the response is deliberately a failure
   assign bad   = bus.mon_out_not !== ~prev_q;
   assign chk_d = &chk_q ? chk_q : chk_q + CNT_W'(1);
   assign err_d = (bad && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         settle_q <= '0;
         prev_q   <= 1'b0;
         cv_q     <= 1'b0;
         mm_q     <= 1'b0;
         chk_q    <= '0;
         err_q    <= '0;
         lbi_q    <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         cv_q <= 1'b0;
         mm_q <= 1'b0;
         if (!bus.enable) state_q <= IDLE;
         else begin
            case (state_q)
               IDLE: begin
                  state_q  <= SETTLE;
                  prev_q   <= bus.mon_in_not;
                  settle_q <= '0;
               end
               SETTLE: begin
                  if (bus.mon_in_not != prev_q) begin
                     prev_q   <= bus.mon_in_not;
                     settle_q <= '0;
                  end else if (settle_q == SETTLE_LAST) state_q <= CHECK;
                  else settle_q <= settle_q + 4'd1;
               end
               CHECK: begin
                  state_q <= HOLD;
                  cv_q    <= 1'b1;
                  mm_q    <= bad;
                  chk_q   <= chk_d;
                  err_q   <= err_d;
                  pass_q  <= (|chk_d) && (err_d == '0);
                  if (bad) lbi_q <= prev_q;
               end
               HOLD: begin
                  if (bus.mon_in_not != prev_q) begin
                     state_q  <= SETTLE;
                     prev_q   <= bus.mon_in_not;
                     settle_q <= '0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign bus.check_valid = cv_q;
   assign bus.mismatch    = mm_q;
   assign bus.check_count = chk_q;
   assign bus.err_count   = err_q;
   assign bus.last_bad_in = lbi_q;
   assign bus.pass        = pass_q;
endmodule

// File: doc/not_gate_monitor.md
NOT_GATE_MONITOR -- requirements
Module: not_gate_monitor

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: the number of clock cycles the stimulus must stay stable before the response is checked; legal range is 1..15.
REQ-002 Parameter CNT_W, default 8: the width of both counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  monitoring enabled when high.
REQ-006 mon_in_not  input  1  observed inverter input, i.e. the stimulus.
REQ-007 mon_out_not  input  1  observed inverter output, i.e. the response.
REQ-008 check_valid  output  1  one-cycle pulse each time a comparison is performed.
REQ-009 mismatch  output  1  one-cycle pulse, coincident with check_valid, when the comparison fails.
REQ-010 check_count  output  CNT_W  number of comparisons performed; saturates at all-ones.
REQ-011 err_count  output  CNT_W  number of failed comparisons; saturates at all-ones.
REQ-012 last_bad_in  output  1  mon_in_not value captured at the most recent failed comparison.
REQ-013 pass  output  1  high when check_count is nonzero and err_count is zero.

Function
REQ-014 The block shall be a four-state FSM with states IDLE, SETTLE, CHECK and HOLD, plus a settle counter and a 1-bit registered copy of mon_in_not (prev_in).
REQ-015 IDLE: when enable=1, go to SETTLE, load prev_in with mon_in_not, and clear the settle counter.
REQ-016 SETTLE: each cycle, if mon_in_not != prev_in, reload prev_in and clear the counter (restart the settle window); otherwise increment the counter.
REQ-017 SETTLE: when the counter reaches SETTLE_CYCLES-1 with the stimulus unchanged, go to CHECK on the next edge.
REQ-018 CHECK: the state lasts exactly one cycle.
REQ-019 CHECK: check_valid shall be registered high in the following cycle.
REQ-020 CHECK: mismatch shall be registered high in the following cycle iff mon_out_not != ~prev_in.
REQ-021 CHECK: check_count increments by 1; on a failure, err_count increments by 1 and last_bad_in is loaded with prev_in.
REQ-022 CHECK: the next state is HOLD.
REQ-023 HOLD: no comparison is performed; when mon_in_not != prev_in, go to SETTLE with prev_in reloaded and the counter cleared.
REQ-024 Latency: a stimulus change seen at edge N, then held stable, shall produce check_valid at edge N+SETTLE_CYCLES+1.
REQ-025 A stimulus toggle in the same cycle that CHECK is entered shall not abort that check; the toggle shall be taken up by HOLD on the next cycle.
REQ-026 enable=0 in any state shall return the FSM to IDLE on the next edge, without clearing the counters or last_bad_in.
REQ-027 enable=0 shall suppress any pending check (a CHECK is not entered).
REQ-028 Counter saturation: at all-ones, a counter shall hold; err_count shall never exceed check_count.
REQ-029 When err_count is saturated, mismatch shall still pulse and last_bad_in shall still update.
REQ-030 X/Z on mon_out_not during CHECK shall count as a mismatch; the comparison uses the case-inequality operator.
REQ-031 pass shall be a registered output.

Reset
REQ-032 While reset=1 at a rising edge: state shall be IDLE; check_valid, mismatch, check_count, err_count, last_bad_in and pass shall be 0; the settle counter and prev_in shall be 0.
REQ-033 Reset has priority over enable and over any in-progress SETTLE or CHECK.
REQ-034 No check_valid pulse shall occur on the cycle after reset deasserts.

Verification
REQ-035 Correct inverter: with SETTLE_CYCLES=2 and enable=1, drive in=0/out=1, then in=1/out=0, each held for 5 cycles -> two check_valid pulses, mismatch never high, check_count=2, err_count=0, pass=1.
REQ-036 Stuck output: with out tied to 0, drive in=0 held for 5 cycles -> one mismatch pulse, err_count=1, last_bad_in=0, pass=0.
REQ-037 Glitchy stimulus: toggle in every cycle for 6 cycles, then hold -> no check_valid until SETTLE_CYCLES+1 cycles after the last toggle, and then exactly one check.
REQ-038 Mid-operation: assert reset during SETTLE -> all outputs 0 on the next cycle; after release, a stable in=1/out=0 yields check_count=1.
REQ-039 Saturation: with CNT_W=2 and out stuck at 1, drive 5 checks with in=1 -> check_count=3, err_count=3, and mismatch pulses on all 5 checks.
REQ-040 Enable drop: deassert enable during SETTLE -> no check is performed, counts are unchanged, and the FSM is in IDLE next cycle.
